// File: rtl/ram8_master.sv
// ram8_master -- command-driven master for a small single-port RAM.
//
// Accepts WRITE / READ / FILL / DUMP commands on a valid/ready command port.
// It drives an external RAM that has a combinational read path. Read data is
// returned on a valid/ready response port.
//   WRITE : one RAM write of the captured data at the captured address.
//   READ  : one RAM read, returned as a single response.
//   FILL  : writes the captured data to DEPTH consecutive addresses (wrapping).
//   DUMP  : reads DEPTH consecutive addresses (wrapping), one response each.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_op[1:0]                 00 WRITE, 01 READ, 10 FILL, 11 DUMP
//   cmd_addr, cmd_data          target/start address, write/fill value
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_addr          read word and the address it came from
//   ram_in, ram_addr, ram_ld    RAM write data, address, write enable
//   ram_out                     RAM read data (combinational from ram_addr)
//   busy                        high whenever a command is in progress
module ram8_master #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [WIDTH-1:0]  ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ld,
  input  logic [WIDTH-1:0]  ram_out,
  output logic              busy
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  // Count value of the last word of a FILL/DUMP burst (DEPTH-1).
  localparam logic [ADDR_W-1:0] LAST_CNT = '1;
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_FILL,
    S_DUMP
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [WIDTH-1:0]  data_reg;
  logic [WIDTH-1:0]  rsp_data_reg;
  logic [ADDR_W-1:0] rsp_addr_reg;

  // A burst continues after a response only for DUMP words before the last.
  logic more_words;
  assign more_words = (op_reg == OP_DUMP) && (cnt_reg != LAST_CNT);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers: command capture, pointer/count, response words
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg       <= '0;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      data_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_addr_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // cmd_ready is high in IDLE, so cmd_valid alone means acceptance.
          if (cmd_valid) begin
            op_reg   <= cmd_op;
            ptr_reg  <= cmd_addr;
            data_reg <= cmd_data;
            cnt_reg  <= '0;
          end
        end
        S_READ, S_DUMP: begin
          rsp_data_reg <= ram_out;
          rsp_addr_reg <= ptr_reg;
        end
        S_RESP: begin
          if (rsp_ready && more_words) begin
            ptr_reg <= ptr_reg + ONE;
            cnt_reg <= cnt_reg + ONE;
          end
        end
        S_FILL: begin
          // Pointer wraps naturally at ADDR_W bits.
          ptr_reg <= ptr_reg + ONE;
          cnt_reg <= cnt_reg + ONE;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: state_next = S_WRITE;
            OP_READ:  state_next = S_READ;
            OP_FILL:  state_next = S_FILL;
            default:  state_next = S_DUMP;
          endcase
        end
      end
      S_WRITE: state_next = S_IDLE;
      S_READ:  state_next = S_RESP;
      S_DUMP:  state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_next = more_words ? S_DUMP : S_IDLE;
        end
      end
      S_FILL: begin
        if (cnt_reg == LAST_CNT) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs. ram_ld decodes straight from the state register so an
  // asynchronous reset removes the write enable immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    ram_ld    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WRITE, S_FILL: ram_ld    = 1'b1;
      S_RESP:          rsp_valid = 1'b1;
      default: ;
    endcase
    ram_addr = ptr_reg;
    ram_in   = data_reg;
    rsp_data = rsp_data_reg;
    rsp_addr = rsp_addr_reg;
  end

endmodule

// File: tb/tb_ram8_master.sv
// tb_ram8_master -- self-checking bench for ram8_master.
//
// Provides the external RAM and drives commands and rsp_ready. A
// transaction-level model predicts the following:
//   - the pending RAM writes (address/data queue);
//   - the pending responses (address/data queue);
//   - the one-cycle response gap before each word.
// One negedge process compares every DUT output against the model on every
// cycle. Directed scenarios add hand-computed literal expectations.
module tb_ram8_master;

  localparam int W     = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic [AW-1:0] rsp_addr;
  logic [W-1:0]  ram_in;
  logic [AW-1:0] ram_addr;
  logic          ram_ld;
  logic [W-1:0]  ram_out;
  logic          busy;

  always #5 clk = ~clk;

  ram8_master #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .ram_in    (ram_in),
    .ram_addr  (ram_addr),
    .ram_ld    (ram_ld),
    .ram_out   (ram_out),
    .busy      (busy)
  );

  // External RAM: synchronous write, combinational read.
  logic [W-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_ld) ram[ram_addr] <= ram_in;
  assign ram_out = ram[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
  endtask

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } word_t;

  word_t        wr_q[$];
  word_t        rs_q[$];
  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] last_data = '0;
  int           gap = 0;

  always @(negedge clk) begin : cmp
    bit            eb;
    bit            el;
    bit            ev;
    logic [AW-1:0] a;
    if (!rst_n) begin
      wr_q.delete();
      rs_q.delete();
      gap       = 0;
      last_data = '0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ram_ld",    ram_ld,    0);
      chk("rst_ram_addr",  ram_addr,  0);
      chk("rst_ram_in",    ram_in,    0);
      chk("rst_rsp_data",  rsp_data,  0);
      chk("rst_rsp_addr",  rsp_addr,  0);
      chk("rst_busy",      busy,      0);
      chk("rst_cmd_ready", cmd_ready, 1);
    end else begin
      eb = (wr_q.size() > 0) || (rs_q.size() > 0);
      el = (wr_q.size() > 0);
      ev = (rs_q.size() > 0) && (gap == 0);
      chk("busy",      busy,      eb);
      chk("cmd_ready", cmd_ready, !eb);
      chk("ram_ld",    ram_ld,    el);
      chk("ram_in",    ram_in,    last_data);
      chk("rsp_valid", rsp_valid, ev);
      if (el) chk("ram_addr", ram_addr, wr_q[0].a);
      if (ev) begin
        chk("rsp_data", rsp_data, rs_q[0].d);
        chk("rsp_addr", rsp_addr, rs_q[0].a);
      end
      // Events at the coming rising edge.
      if (el) begin
        ref_mem[wr_q[0].a] = wr_q[0].d;
        void'(wr_q.pop_front());
      end
      if (gap > 0) gap--;
      else if (ev && rsp_ready) begin
        void'(rs_q.pop_front());
        if (rs_q.size() > 0) gap = 1;
      end
      if (!eb && cmd_valid) begin
        last_data = cmd_data;
        case (cmd_op)
          OP_WR: wr_q.push_back({cmd_addr, cmd_data});
          OP_RD: begin
            rs_q.push_back({cmd_addr, ref_mem[cmd_addr]});
            gap = 1;
          end
          OP_FILL: begin
            for (int i = 0; i < DEPTH; i++) begin
              a = AW'(int'(cmd_addr) + i);
              wr_q.push_back({a, cmd_data});
            end
          end
          default: begin
            for (int i = 0; i < DEPTH; i++) begin
              a = AW'(int'(cmd_addr) + i);
              rs_q.push_back({a, ref_mem[a]});
            end
            gap = 1;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------------------
  // Recorders for directed literal checks
  // ------------------------------------------------------------------
  bit    rec_on = 1'b0;
  int    ld_addrs[$];
  word_t rsps[$];
  int    unstable = 0;
  bit    prev_stall = 1'b0;
  word_t prev_w = '0;

  always @(negedge clk) begin
    if (rec_on) begin
      if (ram_ld) ld_addrs.push_back(int'(ram_addr));
      if (rsp_valid && rsp_ready) rsps.push_back({rsp_addr, rsp_data});
      if (prev_stall && ({rsp_addr, rsp_data} != prev_w)) unstable++;
      prev_stall = rsp_valid && !rsp_ready;
      prev_w     = {rsp_addr, rsp_data};
    end
  end

  task automatic rec_clear();
    ld_addrs.delete();
    rsps.delete();
    unstable   = 0;
    prev_stall = 1'b0;
  endtask

  // rsp_ready driver: 0 random, 1 toggle, 2 manual, else always 1.
  int   rr_mode = 3;
  logic rr_manual = 1'b0;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rsp_ready = 1'($urandom_range(0, 1));
      1:       rsp_ready = ~rsp_ready;
      2:       rsp_ready = rr_manual;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Called between posedge and negedge; returns at posedge+1 of the cycle
  // after acceptance, with acc = that cycle's index.
  task automatic send(input logic [1:0] op, input int a, input logic [W-1:0] d, output int acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = AW'(a);
    cmd_data  = d;
    acc       = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready && rst_n) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    int acc;
    int acc2;
    int t0;
    int vcyc;

    repeat (3) @(posedge clk);
    #1;
    // First command is accepted on the first edge after reset release.
    t0    = cyc;
    rst_n = 1'b1;
    send(OP_FILL, 0, 16'h0000, acc);
    chk("first_accept_cycle", acc, t0 + 1);
    wait_idle();

    // WRITE 5 BEEF then READ 5.
    rec_clear();
    rec_on = 1'b1;
    send(OP_WR, 5, 16'hBEEF, acc);
    send(OP_RD, 5, 16'h0000, acc2);
    chk("wr_then_rd_accept_gap", acc2 - acc, 2);
    vcyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        vcyc = cyc;
        break;
      end
    end
    chk("rd_latency", vcyc - acc2, 1);
    chk("rd_data_beef", rsp_data, 16'hBEEF);
    chk("rd_addr_5", rsp_addr, 5);
    wait_idle();
    chk("wr_ld_cycles", ld_addrs.size(), 1);
    if (ld_addrs.size() > 0) chk("wr_ld_addr", ld_addrs[0], 5);

    // FILL 6 with 00A5, then dump everything back.
    rec_clear();
    send(OP_FILL, 6, 16'h00A5, acc);
    wait_idle();
    chk("fill_ld_cycles", ld_addrs.size(), 8);
    for (int i = 0; i < ld_addrs.size() && i < 8; i++)
      chk("fill_addr_seq", ld_addrs[i], (6 + i) % 8);
    chk("fill_busy_after", busy, 0);
    rec_clear();
    send(OP_DUMP, 0, 16'h0000, acc);
    wait_idle();
    chk("fill_dump_count", rsps.size(), 8);
    for (int i = 0; i < rsps.size(); i++) chk("fill_readback", rsps[i].d, 16'h00A5);

    // Preload RAM[i] = i*0101, DUMP from 3 with toggling rsp_ready.
    for (int i = 0; i < DEPTH; i++) begin
      send(OP_WR, i, W'(i * 16'h0101), acc);
      wait_idle();
    end
    rec_clear();
    rr_mode = 1;
    send(OP_DUMP, 3, 16'h0000, acc);
    wait_idle();
    rr_mode = 3;
    chk("dump_count", rsps.size(), 8);
    for (int i = 0; i < rsps.size(); i++) begin
      chk("dump_addr", rsps[i].a, (3 + i) % 8);
      chk("dump_data", rsps[i].d, ((3 + i) % 8) * 16'h0101);
    end
    chk("dump_stable_on_stall", unstable, 0);

    // READ queued behind a FILL is accepted on the first idle cycle.
    send(OP_FILL, 2, 16'h1234, acc);
    send(OP_RD, 4, 16'h0000, acc2);
    chk("read_after_fill_gap", acc2 - acc, 9);
    wait_idle();

    // READ held for 10 cycles, then a single rsp_ready pulse.
    send(OP_WR, 1, 16'hCAFE, acc);
    wait_idle();
    rr_manual = 1'b0;
    rr_mode   = 2;
    @(posedge clk);
    #1;
    send(OP_RD, 1, 16'h0000, acc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 16'hCAFE);
    end
    rr_manual = 1'b1;
    @(negedge clk);
    rr_manual = 1'b0;
    @(negedge clk);
    chk("pulse_busy", busy, 0);
    chk("pulse_valid", rsp_valid, 0);
    rr_mode = 3;
    @(posedge clk);
    #1;

    // Reset in the 4th cycle of FILL 0 (old contents 5A5A).
    send(OP_FILL, 0, 16'h5A5A, acc);
    wait_idle();
    send(OP_FILL, 0, 16'hC3C3, acc);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("ld_before_reset", ram_ld, 1);
    rst_n = 1'b0;
    #1;
    chk("ld_async_drop", ram_ld, 0);
    chk("busy_async_drop", busy, 0);
    chk("valid_in_reset", rsp_valid, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++)
      chk("ram_after_reset", ram[i], (i < 3) ? 16'hC3C3 : 16'h5A5A);
    t0    = cyc;
    rst_n = 1'b1;
    send(OP_DUMP, 0, 16'h0000, acc);
    chk("accept_after_reset", acc, t0 + 1);
    wait_idle();

    // Randomized traffic with random response back-pressure.
    rr_mode = 0;
    for (int n = 0; n < 60; n++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), W'($urandom), acc);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    rr_mode = 3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
